// File: rtl/matrix_writer_if.sv
// Bundle of the matrix_writer request/status signals and the SRAM port-0 write bus.
// The master side (requester) drives start/address/data; the slave side (matrix_writer)
// drives status and the SRAM control/data lines.
interface matrix_writer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int BANDWIDTH  = 16
);
  logic                            start;
  logic [ADDR_WIDTH-1:0]           matrix_addr;
  logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data;
  logic                            busy;
  logic                            done;
  logic [3:0]                      sram_csb;
  logic                            sram_web;
  logic [3:0]                      sram_wmask;
  logic [8:0]                      sram_addr;
  logic [31:0]                     sram_din;

  modport master (
    output start, matrix_addr, matrix_data,
    input  busy, done, sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );

  modport slave (
    input  start, matrix_addr, matrix_data,
    output busy, done, sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );
endinterface

// File: rtl/matrix_writer.sv
// matrix_writer: writes one burst of BANDWIDTH elements into the four shared SRAM macros,
// one registered port-0 operation per cycle, starting at a flat matrix address.
// Address map: macro = addr[11:10], row = addr[9:1], halfword = addr[0] (0 = low half).
// Optional build macro MATRIX_WRITER_PACK_EN: merges two even-aligned neighbouring elements
// into a single full-word write; undefined means one halfword write per element.
module matrix_writer #(
  parameter int NUM_ROWS   = 64,
  parameter int NUM_COLS   = 64,
  parameter int DATA_WIDTH = 16,
  parameter int BANDWIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  matrix_writer_if.slave   bus
);

  localparam int ADDR_WIDTH = $clog2(NUM_ROWS * NUM_COLS);
  localparam int IDX_W      = $clog2(BANDWIDTH) + 1;
  localparam int DATA_BITS  = DATA_WIDTH * BANDWIDTH;

`ifdef MATRIX_WRITER_PACK_EN
  localparam bit PACK_EN = 1'b1;
`else
  localparam bit PACK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            csb_q, csb_d;
  logic                  web_q, web_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [8:0]            addr_q, addr_d;
  logic [31:0]           din_q, din_d;

  // In IDLE the first operation is built straight from the inputs so that it lands on the
  // SRAM bus the cycle after start is accepted; afterwards the latched copies are used.
  logic [ADDR_WIDTH-1:0] cur_base;
  logic [DATA_BITS-1:0]  cur_data;
  logic [IDX_W-1:0]      cur_idx;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  op_pair;
  int                    lo_sel;
  int                    hi_sel;
  logic [DATA_WIDTH-1:0] elem_lo;
  logic [DATA_WIDTH-1:0] elem_hi;
  logic [3:0]            op_csb;
  logic [3:0]            op_wmask;
  logic [31:0]           op_din;
  logic [IDX_W-1:0]      op_step;

  // Build the SRAM operation for the current element index (halfword or packed pair).
  always_comb begin
    cur_base = (state_q == IDLE) ? bus.matrix_addr : base_q;
    cur_data = (state_q == IDLE) ? bus.matrix_data : data_q;
    cur_idx  = (state_q == IDLE) ? '0 : idx_q;
    op_addr  = cur_base + ADDR_WIDTH'(cur_idx);
    op_pair  = PACK_EN && !op_addr[0] && (int'(cur_idx) + 1 < BANDWIDTH);
    lo_sel   = (int'(cur_idx) < BANDWIDTH) ? int'(cur_idx) : 0;
    hi_sel   = (int'(cur_idx) + 1 < BANDWIDTH) ? int'(cur_idx) + 1 : 0;
    elem_lo  = cur_data[lo_sel*DATA_WIDTH +: DATA_WIDTH];
    elem_hi  = cur_data[hi_sel*DATA_WIDTH +: DATA_WIDTH];
    op_csb   = ~(4'b0001 << op_addr[ADDR_WIDTH-1 -: 2]);
    op_wmask = 4'b0011;
    op_din   = {{(32-DATA_WIDTH){1'b0}}, elem_lo};
    op_step  = IDX_W'(1);
    if (op_pair) begin
      op_wmask = 4'b1111;
      op_din   = {elem_hi, elem_lo};
      op_step  = IDX_W'(2);
    end else if (op_addr[0]) begin
      op_wmask = 4'b1100;
      op_din   = {elem_lo, {(32-DATA_WIDTH){1'b0}}};
    end
  end

  // Next-state logic: accept a burst, issue one operation per cycle, then pulse done.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    data_d  = data_q;
    idx_d   = idx_q;
    csb_d   = 4'hF;
    web_d   = 1'b1;
    wmask_d = 4'b0000;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.matrix_addr;
          data_d  = bus.matrix_data;
          csb_d   = op_csb;
          web_d   = 1'b0;
          wmask_d = op_wmask;
          addr_d  = op_addr[9:1];
          din_d   = op_din;
          idx_d   = cur_idx + op_step;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (int'(idx_q) < BANDWIDTH) begin
          csb_d   = op_csb;
          web_d   = 1'b0;
          wmask_d = op_wmask;
          addr_d  = op_addr[9:1];
          din_d   = op_din;
          idx_d   = cur_idx + op_step;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered SRAM outputs; reset releases the port and aborts any burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      csb_q   <= 4'hF;
      web_q   <= 1'b1;
      wmask_q <= 4'b0000;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.sram_csb   = csb_q;
  assign bus.sram_web   = web_q;
  assign bus.sram_wmask = wmask_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_din   = din_q;

endmodule
